// File: rtl/dp_arbiter.sv
// dp_arbiter: two-requester arbiter in front of a shared add/subtract datapath.
//
// Requesters present operands and an opcode with valid/ready. Grants go round
// robin in IDLE; once a requester is granted with last=0 it owns the datapath
// until it issues an operation with last=1. The granted operands are driven
// combinationally to the datapath in the issue cycle. A tag pipeline of LAT+1
// stages tracks {valid, id} so each result comes back as a one-cycle response
// in issue order.
//
// Parameters:
//   N   operand/result width
//   LAT datapath latency, operand to dp_Y/dp_co (0..2)
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   rX_valid/rX_ready          requester X handshake
//   rX_a, rX_b, rX_op, rX_last requester X operands, opcode, end-of-burst
//   dp_A, dp_B, dp_opcode      datapath operands (0 when nothing issues)
//   dp_Y, dp_co                datapath result and carry-out
//   rsp_valid, rsp_id          one-cycle response strobe and owner id
//   rsp_y, rsp_co              registered result, held between responses
//   cnt0, cnt1                 per-requester saturating issue counters
//                              (only when DP_ARB_STATS_EN is defined)
//
// State table:
//   IDLE | no owner; grant single valid requester, or pointer on contention
//   OWN0 | requester 0 is mid-burst; requester 1 stalled
//   OWN1 | requester 1 is mid-burst; requester 0 stalled
module dp_arbiter #(
    parameter int N   = 16,
    parameter int LAT = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         r0_valid,
    output logic         r0_ready,
    input  logic [N-1:0] r0_a,
    input  logic [N-1:0] r0_b,
    input  logic [2:0]   r0_op,
    input  logic         r0_last,
    input  logic         r1_valid,
    output logic         r1_ready,
    input  logic [N-1:0] r1_a,
    input  logic [N-1:0] r1_b,
    input  logic [2:0]   r1_op,
    input  logic         r1_last,
    output logic [N-1:0] dp_A,
    output logic [N-1:0] dp_B,
    output logic [2:0]   dp_opcode,
    input  logic [N-1:0] dp_Y,
    input  logic         dp_co,
    output logic         rsp_valid,
    output logic         rsp_id,
    output logic [N-1:0] rsp_y,
    output logic         rsp_co
`ifdef DP_ARB_STATS_EN
    ,
    output logic [15:0]  cnt0,
    output logic [15:0]  cnt1
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t state;
    logic   ptr;
    logic   gnt0;
    logic   gnt1;
    logic   issue;
    logic   issue_id;

    // Grants already include the valid input, so a grant is an issue.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        case (state)
            IDLE: begin
                if (r0_valid && r1_valid) begin
                    gnt0 = ~ptr;
                    gnt1 = ptr;
                end else begin
                    gnt0 = r0_valid;
                    gnt1 = r1_valid;
                end
            end
            OWN0:    gnt0 = r0_valid;
            OWN1:    gnt1 = r1_valid;
            default: ;
        endcase
        if (!rst_n) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end
    end

    assign r0_ready = gnt0;
    assign r1_ready = gnt1;
    assign issue    = gnt0 | gnt1;
    assign issue_id = gnt1;

    always_comb begin
        dp_A      = '0;
        dp_B      = '0;
        dp_opcode = 3'b000;
        if (gnt0) begin
            dp_A      = r0_a;
            dp_B      = r0_b;
            dp_opcode = r0_op;
        end else if (gnt1) begin
            dp_A      = r1_a;
            dp_B      = r1_b;
            dp_opcode = r1_op;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= 1'b0;
        end else if (gnt0) begin
            if (r0_last) begin
                state <= IDLE;
                ptr   <= 1'b1;
            end else begin
                state <= OWN0;
            end
        end else if (gnt1) begin
            if (r1_last) begin
                state <= IDLE;
                ptr   <= 1'b0;
            end else begin
                state <= OWN1;
            end
        end
    end

    // Tag pipeline. Bit 0 of the head vectors is the live issue; bit k is
    // the tag that entered k cycles ago. The tag at position LAT is the one
    // whose result sits on dp_Y this cycle, so the result is captured then.
    logic [LAT:0]   tag_v;
    logic [LAT:0]   tag_id;
    logic [LAT+1:0] head_v;
    logic [LAT+1:0] head_id;

    assign head_v  = {tag_v, issue};
    assign head_id = {tag_id, issue_id};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_v  <= '0;
            tag_id <= '0;
            rsp_y  <= '0;
            rsp_co <= 1'b0;
        end else begin
            tag_v  <= head_v[LAT:0];
            tag_id <= head_id[LAT:0];
            if (head_v[LAT]) begin
                rsp_y  <= dp_Y;
                rsp_co <= dp_co;
            end
        end
    end

    assign rsp_valid = tag_v[LAT];
    assign rsp_id    = tag_id[LAT];

`ifdef DP_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (gnt0 && (cnt0 != 16'hFFFF)) cnt0 <= cnt0 + 16'd1;
            if (gnt1 && (cnt1 != 16'hFFFF)) cnt1 <= cnt1 + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dp_arbiter.sv
// Bench for dp_arbiter: two instances (LAT=0 and LAT=2) share the requester
// inputs; each has its own datapath model. A behavioural model tracks the
// owner, the round-robin pointer and a queue of expected responses.
module tb_dp_arbiter;
    localparam int N = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic         r0_valid = 0, r1_valid = 0, r0_last = 0, r1_last = 0;
    logic [N-1:0] r0_a = 0, r0_b = 0, r1_a = 0, r1_b = 0;
    logic [2:0]   r0_op = 0, r1_op = 0;

    logic         r0_ready_l0, r1_ready_l0, r0_ready_l2, r1_ready_l2;
    logic [N-1:0] dp_A_l0, dp_B_l0, dp_A_l2, dp_B_l2;
    logic [2:0]   dp_op_l0, dp_op_l2;
    logic [N-1:0] dp_Y_l0, dp_Y_l2;
    logic         dp_co_l0, dp_co_l2;
    logic         rsp_valid_l0, rsp_id_l0, rsp_co_l0;
    logic         rsp_valid_l2, rsp_id_l2, rsp_co_l2;
    logic [N-1:0] rsp_y_l0, rsp_y_l2;
`ifdef DP_ARB_STATS_EN
    logic [15:0]  cnt0_l0, cnt1_l0, cnt0_l2, cnt1_l2;
`endif

    dp_arbiter #(.N(N), .LAT(0)) u_dut_l0 (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(r0_valid), .r0_ready(r0_ready_l0), .r0_a(r0_a), .r0_b(r0_b),
        .r0_op(r0_op), .r0_last(r0_last),
        .r1_valid(r1_valid), .r1_ready(r1_ready_l0), .r1_a(r1_a), .r1_b(r1_b),
        .r1_op(r1_op), .r1_last(r1_last),
        .dp_A(dp_A_l0), .dp_B(dp_B_l0), .dp_opcode(dp_op_l0),
        .dp_Y(dp_Y_l0), .dp_co(dp_co_l0),
        .rsp_valid(rsp_valid_l0), .rsp_id(rsp_id_l0), .rsp_y(rsp_y_l0), .rsp_co(rsp_co_l0)
`ifdef DP_ARB_STATS_EN
        , .cnt0(cnt0_l0), .cnt1(cnt1_l0)
`endif
    );

    dp_arbiter #(.N(N), .LAT(2)) u_dut_l2 (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(r0_valid), .r0_ready(r0_ready_l2), .r0_a(r0_a), .r0_b(r0_b),
        .r0_op(r0_op), .r0_last(r0_last),
        .r1_valid(r1_valid), .r1_ready(r1_ready_l2), .r1_a(r1_a), .r1_b(r1_b),
        .r1_op(r1_op), .r1_last(r1_last),
        .dp_A(dp_A_l2), .dp_B(dp_B_l2), .dp_opcode(dp_op_l2),
        .dp_Y(dp_Y_l2), .dp_co(dp_co_l2),
        .rsp_valid(rsp_valid_l2), .rsp_id(rsp_id_l2), .rsp_y(rsp_y_l2), .rsp_co(rsp_co_l2)
`ifdef DP_ARB_STATS_EN
        , .cnt0(cnt0_l2), .cnt1(cnt1_l2)
`endif
    );

    // Attached datapaths: combinational for LAT=0, two register stages for LAT=2.
    function automatic logic [N:0] alu(input logic [N-1:0] a, input logic [N-1:0] b,
                                       input logic [2:0] op);
        logic [N:0] bb;
        bb = op[2] ? '0 : {1'b0, b};
        if (op[1]) bb = bb ^ {1'b0, {N{1'b1}}};
        return {1'b0, a} + bb + {{N{1'b0}}, op[0]};
    endfunction

    assign {dp_co_l0, dp_Y_l0} = alu(dp_A_l0, dp_B_l0, dp_op_l0);

    logic [N:0] dp_s1, dp_s2;
    always_ff @(posedge clk) begin
        dp_s1 <= alu(dp_A_l2, dp_B_l2, dp_op_l2);
        dp_s2 <= dp_s1;
    end
    assign {dp_co_l2, dp_Y_l2} = dp_s2;

    // ---------------- reference model ----------------
    typedef struct {
        int           due;
        logic         id;
        logic [N-1:0] y;
        logic         co;
    } rsp_t;

    rsp_t         q[2][$];
    logic [N-1:0] exp_y[2];
    logic         exp_co[2];
    int           owner;
    int           rr;
    int           mcnt[2];
    int           cyc;
    int           checks;
    int           errors;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_rsp(input int k, input logic v, input logic id,
                             input logic [N-1:0] y, input logic co);
        logic ev;
        logic eid;
        rsp_t e;
        ev  = 1'b0;
        eid = 1'b0;
        if (q[k].size() > 0 && q[k][0].due == cyc) begin
            e         = q[k].pop_front();
            ev        = 1'b1;
            eid       = e.id;
            exp_y[k]  = e.y;
            exp_co[k] = e.co;
        end
        chk($sformatf("rsp_valid_lat%0d", 2 * k), {31'b0, v}, {31'b0, ev});
        if (ev) chk($sformatf("rsp_id_lat%0d", 2 * k), {31'b0, id}, {31'b0, eid});
        chk($sformatf("rsp_y_lat%0d", 2 * k), {16'b0, y}, {16'b0, exp_y[k]});
        chk($sformatf("rsp_co_lat%0d", 2 * k), {31'b0, co}, {31'b0, exp_co[k]});
    endtask

    task automatic step(input logic rst,
                        input logic v0, input logic [N-1:0] a0, input logic [N-1:0] b0,
                        input logic [2:0] op0, input logic l0,
                        input logic v1, input logic [N-1:0] a1, input logic [N-1:0] b1,
                        input logic [2:0] op1, input logic l1);
        int           g;
        int unsigned  sum;
        logic [N-1:0] sa, sb;
        logic [2:0]   sop;
        logic         sl;
        rsp_t         e;
        @(negedge clk);
        cyc++;
        check_rsp(0, rsp_valid_l0, rsp_id_l0, rsp_y_l0, rsp_co_l0);
        check_rsp(1, rsp_valid_l2, rsp_id_l2, rsp_y_l2, rsp_co_l2);
`ifdef DP_ARB_STATS_EN
        chk("cnt0_lat0", {16'b0, cnt0_l0}, mcnt[0]);
        chk("cnt1_lat0", {16'b0, cnt1_l0}, mcnt[1]);
        chk("cnt0_lat2", {16'b0, cnt0_l2}, mcnt[0]);
        chk("cnt1_lat2", {16'b0, cnt1_l2}, mcnt[1]);
`endif
        rst_n = rst;
        r0_valid = v0; r0_a = a0; r0_b = b0; r0_op = op0; r0_last = l0;
        r1_valid = v1; r1_a = a1; r1_b = b1; r1_op = op1; r1_last = l1;
        #1;
        g = -1;
        if (!rst) begin
            owner = -1;
            rr = 0;
            q[0].delete();
            q[1].delete();
            exp_y  = '{default: '0};
            exp_co = '{default: 1'b0};
            mcnt   = '{default: 0};
        end else if (owner == 0) begin
            if (v0) g = 0;
        end else if (owner == 1) begin
            if (v1) g = 1;
        end else if (v0 && v1) begin
            g = rr;
        end else if (v0) begin
            g = 0;
        end else if (v1) begin
            g = 1;
        end
        chk("r0_ready_lat0", {31'b0, r0_ready_l0}, (g == 0) ? 1 : 0);
        chk("r1_ready_lat0", {31'b0, r1_ready_l0}, (g == 1) ? 1 : 0);
        chk("r0_ready_lat2", {31'b0, r0_ready_l2}, (g == 0) ? 1 : 0);
        chk("r1_ready_lat2", {31'b0, r1_ready_l2}, (g == 1) ? 1 : 0);
        sa = '0; sb = '0; sop = 3'b000; sl = 1'b0;
        if (g == 0) begin sa = a0; sb = b0; sop = op0; sl = l0; end
        if (g == 1) begin sa = a1; sb = b1; sop = op1; sl = l1; end
        chk("dp_A", {16'b0, dp_A_l0}, {16'b0, sa});
        chk("dp_B", {16'b0, dp_B_l2}, {16'b0, sb});
        chk("dp_opcode", {29'b0, dp_op_l0}, {29'b0, sop});
        if (g >= 0) begin
            // Y = A + ((op2 ? 0 : B) xor all-op1) + op0, carry is bit N
            sum = int'(sa) + (sop[2] ? 0 : (sop[1] ? (65535 - int'(sb)) : int'(sb)))
                  + (sop[1] && sop[2] ? 65535 : 0) + int'(sop[0]);
            e.id = (g == 1);
            e.y  = sum[N-1:0];
            e.co = sum[N];
            e.due = cyc + 1;
            q[0].push_back(e);
            e.due = cyc + 3;
            q[1].push_back(e);
            if (mcnt[g] < 65535) mcnt[g]++;
            if (sl) begin
                owner = -1;
                rr = 1 - g;
            end else begin
                owner = g;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        owner = -1; rr = 0; cyc = 0; checks = 0; errors = 0;
        exp_y  = '{default: '0};
        exp_co = '{default: 1'b0};
        mcnt   = '{default: 0};
        #1 rst_n = 1'b0;

        // held in reset with both requesters valid: no readies, no responses
        step(0, 1, 16'd1, 16'd1, 3'b000, 1, 1, 16'd2, 16'd2, 3'b000, 1);
        step(0, 1, 16'd1, 16'd1, 3'b000, 1, 1, 16'd2, 16'd2, 3'b000, 1);

        // both valid, last=1, from reset: alternating grants, 4 each
        for (int i = 0; i < 8; i++)
            step(1, 1, 16'($urandom), 16'($urandom), 3'($urandom), 1,
                    1, 16'($urandom), 16'($urandom), 3'($urandom), 1);
        idle(3);

        // single add and both subtraction directions
        step(1, 1, 16'd5, 16'd3, 3'b000, 1, 0, 0, 0, 0, 0);
        idle(1);
        step(1, 1, 16'd5, 16'd3, 3'b011, 1, 0, 0, 0, 0, 0);
        step(1, 1, 16'd3, 16'd5, 3'b011, 1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 1, 16'hFFFF, 16'h0001, 3'b000, 1);
        step(1, 0, 0, 0, 0, 0, 1, 16'h1234, 16'hFFFF, 3'b100, 1);
        step(1, 1, 16'h8000, 16'h0000, 3'b111, 1, 0, 0, 0, 0, 0);
        idle(3);

        // r0 locked burst of three while r1 waits, then r1 is granted
        step(1, 1, 16'd10, 16'd1, 3'b000, 0, 1, 16'd7, 16'd7, 3'b000, 1);
        step(1, 1, 16'd11, 16'd2, 3'b000, 0, 1, 16'd7, 16'd7, 3'b000, 1);
        step(1, 1, 16'd12, 16'd3, 3'b000, 1, 1, 16'd7, 16'd7, 3'b000, 1);
        step(1, 0, 0, 0, 0, 0, 1, 16'd7, 16'd7, 3'b000, 1);
        idle(3);

        // four back-to-back issues, ids 0,1,0,1
        for (int i = 0; i < 4; i++)
            step(1, 1, 16'(100 + i), 16'd1, 3'b000, 1, 1, 16'(200 + i), 16'd2, 3'b000, 1);
        idle(4);

        // randomized traffic
        for (int i = 0; i < 300; i++)
            step(1, 1'($urandom), 16'($urandom), 16'($urandom), 3'($urandom),
                    ($urandom_range(0, 2) != 0),
                    1'($urandom), 16'($urandom), 16'($urandom), 3'($urandom),
                    ($urandom_range(0, 2) != 0));
        idle(4);

        // reset mid-burst with results in flight
        step(1, 1, 16'd1, 16'd2, 3'b000, 0, 1, 16'd3, 16'd4, 3'b000, 1);
        step(1, 1, 16'd5, 16'd6, 3'b000, 0, 1, 16'd3, 16'd4, 3'b000, 1);
        step(0, 1, 16'd5, 16'd6, 3'b000, 0, 1, 16'd3, 16'd4, 3'b000, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(6);
        step(1, 1, 16'd9, 16'd9, 3'b000, 1, 1, 16'd8, 16'd8, 3'b000, 1);
        idle(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/dp_arbiter.md
DP_ARBITER -- requirements
Module: dp_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 16, giving the operand and result width in bits.
REQ-002 The block SHALL have parameter LAT, default 0, legal values 0..2, giving the latency of the attached datapath from operand to dp_Y/dp_co, in cycles.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low. Ports: clk  in  1  clock; rst_n  in  1  asynchronous active-low reset.
REQ-004 r0_valid  in  1  requester 0 has an operation pending.
REQ-005 r0_ready  out  1  requester 0 operation accepted this cycle.
REQ-006 r0_a, r0_b  in  N  requester 0 signed operands.
REQ-007 r0_op  in  3  requester 0 opcode: bit2 zeroes B, bit1 inverts B, bit0 is carry-in.
REQ-008 r0_last  in  1  the accepted operation ends requester 0's locked burst.
REQ-009 r1_valid, r1_ready, r1_a, r1_b, r1_op, r1_last SHALL match r0_* for requester 1.
REQ-010 dp_A, dp_B  out  N  datapath operands.
REQ-011 dp_opcode  out  3  datapath opcode.
REQ-012 dp_Y  in  N  datapath result; dp_co  in  1  datapath carry-out.
REQ-013 rsp_valid  out  1  response valid for exactly one cycle, no backpressure.
REQ-014 rsp_id  out  1  index of the requester that owns the response.
REQ-015 rsp_y  out  N  registered result; rsp_co  out  1  registered carry-out.

Function
REQ-016 An issue SHALL occur when rX_valid and rX_ready are both 1 in the same cycle; at most one issue SHALL occur per cycle.
REQ-017 FSM states SHALL be IDLE, OWN0 and OWN1.
REQ-018 In IDLE with one requester valid, the block SHALL grant that requester; with both valid, it SHALL grant the one selected by a round-robin pointer.
REQ-019 In OWNx, only rx_ready SHALL be able to assert (rx_ready = rx_valid); the other requester SHALL be stalled.
REQ-020 An issue with last=0 SHALL transition to OWNx (or stay there); an issue with last=1 SHALL transition to IDLE.
REQ-021 The round-robin pointer SHALL point to the other requester after any issue with last=1, and SHALL be unchanged otherwise.
REQ-022 rX_ready SHALL be combinational from the state, the pointer and both valid inputs; it SHALL never depend on rsp_*.
REQ-023 dp_A, dp_B and dp_opcode SHALL carry the granted requester's a, b and op combinationally in the issue cycle; with no issue they SHALL be 0, 0 and 3'b000.
REQ-024 The block SHALL keep a tag pipeline of LAT+1 stages holding {valid, id}; an issue at cycle t SHALL give rsp_valid=1 at t+LAT+1, with rsp_y/rsp_co equal to dp_Y/dp_co registered at cycle t+LAT.
REQ-025 Responses SHALL return in issue order; back-to-back issues SHALL give back-to-back responses.
REQ-026 rsp_y and rsp_co SHALL hold their last value while rsp_valid=0.
REQ-027 The block SHALL pass the opcode through unmodified and SHALL perform no arithmetic itself; the expected result is Y = A + ((op[2]?0:B) XOR {N{op[1]}}) + op[0], modulo 2^N, with co as bit N.

Reset
REQ-028 While rst_n=0, the state SHALL be IDLE, the pointer SHALL select requester 0, all tag stages SHALL be invalid, rsp_valid/rsp_id/rsp_y/rsp_co SHALL be 0, and both ready outputs SHALL be 0.
REQ-029 Reset asserted mid-burst or with results in flight SHALL discard those results without issuing a response.

Configuration
REQ-030 With DP_ARB_STATS_EN defined, the block SHALL add outputs cnt0 and cnt1 (out, 16 bits): per-requester issue counters that reset to 0 and saturate at 16'hFFFF.
REQ-031 Without DP_ARB_STATS_EN, the block SHALL have neither the ports nor the counters; all other behaviour SHALL be identical.

Verification
REQ-032 LAT=0, r0 issues a=5, b=3, op=000, last=1 -> r0_ready=1 in the same cycle; the next cycle gives rsp_valid=1, rsp_id=0, rsp_y=8, rsp_co=0.
REQ-033 Subtraction, op=011: a=5, b=3 -> rsp_y=16'h0002, co=1; a=3, b=5 -> rsp_y=16'hFFFE, co=0.
REQ-034 Both requesters continuously valid with last=1 from reset -> grants alternate 0,1,0,1; with STATS_EN, after 8 cycles cnt0=4 and cnt1=4.
REQ-035 r0 bursts three ops (last=0,0,1) while r1 is valid -> r1_ready=0 for 3 cycles, then r1 is granted; the state goes OWN0 -> IDLE.
REQ-036 LAT=2, four back-to-back issues with ids 0,1,0,1 -> rsp_valid high in cycles t+3..t+6 with ids in the same order.
REQ-037 rst_n pulsed low with two results in flight -> no rsp_valid pulse follows; the state returns to IDLE; the pointer selects r0.
